dish_cycle_timer: RTL

Cycle timer and supervisor for the automatic dish-washing controller. It watches the controller's valve and lock outputs plus the drain sensor, and generates the `Washing_Timeout` and `Store_Timeout` inputs the controller needs. Durations come from a program selected at `Start`. A fill watchdog raises a sticky fault when the fill valve stays open too long. The block sits between the dish-washer FSM and a prescaled time base (`Tick`).

---
 rtl/dish_cycle_timer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dish_cycle_timer.sv
// dish_cycle_timer: phase timer and fill watchdog
// for the dish-washer controller.
module dish_cycle_timer #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned WASH_ECO       = 300,
    parameter int unsigned WASH_NORMAL    = 600,
    parameter int unsigned WASH_INTENSIVE = 1200,
    parameter int unsigned STORE_TICKS    = 200,
    parameter int unsigned FILL_LIMIT     = 400
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Tick,
    input  logic             Start,
    input  logic [1:0]       Program,
    input  logic             Door_Lock,
    input  logic             Fill_valve_on,
    input  logic             Fill_valve_second_on,
    input  logic             Drained,
    input  logic             Done,
    output logic             Washing_Timeout,
    output logic             Store_Timeout,
    output logic             Fill_Fault,
    output logic             Busy,
    output logic [CNT_W-1:0] Remaining
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        FILL,
        WAIT_WASH,
        WASH,
        DRAIN,
        STORE,
        FAULT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] wash_val;
    logic             load_en;
    logic             clr_cnt;
    logic [1:0]       prog_q;
    logic [1:0]       prog_d;
    logic             cnt_zero;
    logic             in_phase;
    logic             abort;

    assign cnt_zero = (cnt_q == '0);

    // Wash duration for the latched program (11 already folded to 01).
    always_comb begin
        wash_val = CNT_W'(WASH_NORMAL);
        unique case (1'b1)
            (prog_q == 2'b00): wash_val = CNT_W'(WASH_ECO);
            (prog_q == 2'b10): wash_val = CNT_W'(WASH_INTENSIVE);
            default:           wash_val = CNT_W'(WASH_NORMAL);
        endcase
    end

    // Door opened mid-cycle; Done in STORE is a normal exit instead.
    always_comb begin
        in_phase = (state_q == FILL)
                || (state_q == WAIT_WASH)
                || (state_q == WASH)
                || (state_q == DRAIN)
                || (state_q == STORE);
        abort = in_phase && !Door_Lock
             && !((state_q == STORE) && Done);
    end

    // Next state, counter load requests and program latch.
    always_comb begin
        state_d  = state_q;
        prog_d   = prog_q;
        load_en  = 1'b0;
        load_val = '0;
        clr_cnt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    prog_d  = (Program == 2'b11) ? 2'b01
                                                 : Program;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (Fill_valve_on) begin
                    load_en  = 1'b1;
                    load_val = CNT_W'(FILL_LIMIT);
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (!Fill_valve_on) begin
                    state_d = WAIT_WASH;
                end else if (cnt_zero) begin
                    state_d = FAULT;
                end
            end
            WAIT_WASH: begin
                if (Fill_valve_second_on) begin
                    load_en  = 1'b1;
                    load_val = wash_val;
                    state_d  = WASH;
                end
            end
            WASH: begin
                if (cnt_zero && !Fill_valve_second_on) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (Drained) begin
                    load_en  = 1'b1;
                    load_val = CNT_W'(STORE_TICKS);
                    state_d  = STORE;
                end
            end
            STORE: begin
                if (Done) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            load_en = 1'b0;
            clr_cnt = 1'b1;
        end
    end

    // State and latched program registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            prog_q  <= 2'b01;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
        end
    end

    // Phase counter: load beats Tick, decrement saturates at 0.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if (load_en) begin
            cnt_q <= load_val;
        end else if (Tick && !cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Outputs come from registered state and counter only.
    always_comb begin
        Washing_Timeout = (state_q == WASH) && cnt_zero;
        Store_Timeout   = (state_q == STORE) && cnt_zero;
        Fill_Fault      = (state_q == FAULT);
        Busy            = (state_q != IDLE)
                       && (state_q != FAULT);
        Remaining       = cnt_q;
    end

endmodule
